// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode. Buffers up to DEPTH
// {instruction, next-PC} pairs behind a valid/ready handshake, drops its
// whole contents on a taken branch and counts decode-starved cycles.
module if_id_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             IF_valid,
  input  logic [WIDTH-1:0] IF_instr,
  input  logic [WIDTH-1:0] IF_npc,
  output logic             IF_ready,
  input  logic             ID_ready,
  output logic             ID_valid,
  output logic [WIDTH-1:0] IF_ID_instrout,
  output logic [WIDTH-1:0] IF_ID_npcout,
  input  logic             EX_MEM_PCSrc,
  output logic [PTR_W:0]   count,
  output logic [15:0]      bubble_cnt
);

  localparam logic [PTR_W:0] CountFull = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [WIDTH-1:0] npc_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [15:0]      bubble_q, bubble_d;
  logic             push, pop;

  // Readiness depends on occupancy only, so a full queue never pushes on a pop cycle.
  assign IF_ready   = (count_q != CountFull);
  assign ID_valid   = (count_q != '0);
  assign push       = IF_valid & IF_ready & ~EX_MEM_PCSrc;
  assign pop        = ID_valid & ID_ready & ~EX_MEM_PCSrc;
  assign count      = count_q;
  assign bubble_cnt = bubble_q;

  // Head outputs read straight from storage, forced to NOP when empty.
  always_comb begin
    IF_ID_instrout = '0;
    IF_ID_npcout   = '0;
    if (ID_valid) begin
      IF_ID_instrout = instr_q[rd_ptr_q];
      IF_ID_npcout   = npc_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy and bubble counter; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    bubble_d = bubble_q;
    if (EX_MEM_PCSrc) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
    // Starvation is counted regardless of flush; saturates rather than wraps.
    if (ID_ready && !ID_valid && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bubble_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bubble_q <= bubble_d;
    end
  end

  // Entry storage; contents survive flush and reset, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      instr_q[wr_ptr_q] <= IF_instr;
      npc_q[wr_ptr_q]   <= IF_npc;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue with a scoreboard queue of expected pairs.
module tb_if_id_queue;
  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n, IF_valid, IF_ready, ID_ready, ID_valid, EX_MEM_PCSrc;
  logic [W-1:0] IF_instr, IF_npc, IF_ID_instrout, IF_ID_npcout;
  logic [2:0]   count;
  logic [15:0]  bubble_cnt;

  logic [2*W-1:0] sb [$];
  int             m_bub;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  if_id_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .IF_valid      (IF_valid),
    .IF_instr      (IF_instr),
    .IF_npc        (IF_npc),
    .IF_ready      (IF_ready),
    .ID_ready      (ID_ready),
    .ID_valid      (ID_valid),
    .IF_ID_instrout(IF_ID_instrout),
    .IF_ID_npcout  (IF_ID_npcout),
    .EX_MEM_PCSrc  (EX_MEM_PCSrc),
    .count         (count),
    .bubble_cnt    (bubble_cnt)
  );

  // Drive one cycle, update the reference model, sample #1 after the edge.
  task automatic cycle(input logic iv, input logic [W-1:0] ins, input logic [W-1:0] np,
                       input logic ir, input logic fl);
    bit push, pop;
    IF_valid = iv; IF_instr = ins; IF_npc = np; ID_ready = ir; EX_MEM_PCSrc = fl;
    push = iv && (sb.size() != D) && !fl;
    pop  = (sb.size() != 0) && ir && !fl;
    if (ir && sb.size() == 0 && m_bub < 65535) m_bub++;
    if (fl) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back({ins, np});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic iv, input logic fl);
    reset_n = 1'b0; IF_valid = iv; IF_instr = 32'hDEAD; IF_npc = 32'hBEEF;
    ID_ready = 1'b0; EX_MEM_PCSrc = fl;
    @(posedge clk); #1;
    reset_n = 1'b1; IF_valid = 1'b0; EX_MEM_PCSrc = 1'b0;
    sb.delete(); m_bub = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b exp 0", ID_valid); end
    checks++; if (IF_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %b exp 1", IF_ready); end
    checks++; if (IF_ID_instrout !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", IF_ID_instrout); end
    checks++; if (IF_ID_npcout !== 32'h0) begin errors++; $display("FAIL reset_npc got %h exp 0", IF_ID_npcout); end
    checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL reset_bubble got %h exp 0", bubble_cnt); end
  endtask

  task automatic test_single_push();
    do_reset(1'b0, 1'b0);
    cycle(1'b1, 32'h20080005, 32'h4, 1'b0, 1'b0);
    IF_valid = 1'b0;
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ID_valid); end
    checks++; if (IF_ID_instrout !== 32'h20080005) begin errors++; $display("FAIL single_instr got %h exp 20080005", IF_ID_instrout); end
    checks++; if (IF_ID_npcout !== 32'h4) begin errors++; $display("FAIL single_npc got %h exp 4", IF_ID_npcout); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
  endtask

  task automatic test_fill_drain();
    logic [2*W-1:0] exp;
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (IF_ready !== (i <= D)) begin
        errors++; $display("FAIL fill_if_ready push %0d got %b exp %b", i, IF_ready, (i <= D));
      end
      cycle(1'b1, W'(i), W'(i * 4), 1'b0, 1'b0);
    end
    IF_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    // Stalled decode must keep seeing the same head.
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (IF_ID_instrout !== 32'h1) begin errors++; $display("FAIL stall_hold got %h exp 1", IF_ID_instrout); end
    for (int k = 1; k <= D; k++) begin
      exp = sb[0];
      checks++;
      if ({IF_ID_instrout, IF_ID_npcout} !== exp || IF_ID_instrout !== W'(k)) begin
        errors++; $display("FAIL drain_head %0d got %h/%h exp %h/%h", k, IF_ID_instrout,
                           IF_ID_npcout, exp[2*W-1:W], exp[W-1:0]);
      end
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end
    checks++; if (count !== 3'd0 || ID_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty count %0d valid %b exp 0 0", count, ID_valid);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < D; i++) cycle(1'b1, 32'hA0 + W'(i), W'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hFF, 32'hFF, 1'b1, 1'b0);
    IF_valid = 1'b0;
    checks++; if (count !== 3'(D - 1)) begin errors++; $display("FAIL full_pushpop_count got %0d exp %0d", count, D - 1); end
    checks++; if (IF_ID_instrout !== 32'hA1) begin errors++; $display("FAIL full_pushpop_head got %h exp a1", IF_ID_instrout); end
  endtask

  task automatic test_stream();
    logic [2*W-1:0] exp;
    do_reset(1'b0, 1'b0);
    cycle(1'b1, 32'h100, 32'h200, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) begin
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count %0d got %0d exp 1", i, count); end
      exp = sb[0];
      checks++;
      if ({IF_ID_instrout, IF_ID_npcout} !== exp || IF_ID_instrout !== 32'h100 + W'(i - 1)) begin
        errors++; $display("FAIL stream_head %0d got %h/%h exp %h/%h", i, IF_ID_instrout,
                           IF_ID_npcout, exp[2*W-1:W], exp[W-1:0]);
      end
      cycle(1'b1, 32'h100 + W'(i), 32'h200 + W'(i), 1'b1, 1'b0);
    end
    IF_valid = 1'b0;
    checks++; if (IF_ID_instrout !== 32'h109) begin errors++; $display("FAIL stream_last got %h exp 109", IF_ID_instrout); end
  endtask

  task automatic test_flush();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h50 + W'(i), W'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD, 32'hDEAD, 1'b0, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (ID_valid !== 1'b0 || IF_ready !== 1'b1) begin
      errors++; $display("FAIL flush_flags valid %b ready %b exp 0 1", ID_valid, IF_ready);
    end
    checks++; if (IF_ID_instrout !== 32'h0) begin errors++; $display("FAIL flush_head got %h exp 0", IF_ID_instrout); end
    // Starved cycle during flush still counts as a bubble.
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (bubble_cnt !== 16'(m_bub)) begin errors++; $display("FAIL flush_bubble got %0d exp %0d", bubble_cnt, m_bub); end
    cycle(1'b1, 32'h8, 32'hC, 1'b0, 1'b0);
    IF_valid = 1'b0;
    checks++; if (IF_ID_instrout !== 32'h8 || count !== 3'd1) begin
      errors++; $display("FAIL flush_next got %h cnt %0d exp 8 cnt 1", IF_ID_instrout, count);
    end
  endtask

  task automatic test_bubble();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (bubble_cnt !== 16'd20) begin errors++; $display("FAIL bubble_20 got %0d exp 20", bubble_cnt); end
    for (int i = 0; i < 65514; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (bubble_cnt !== 16'hFFFE) begin errors++; $display("FAIL bubble_fffe got %h exp fffe", bubble_cnt); end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL bubble_sat got %h exp ffff", bubble_cnt); end
  endtask

  task automatic test_reset_full();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) cycle(1'b1, 32'h70 + W'(i), W'(i), 1'b0, 1'b0);
    checks++; if (count !== 3'd4 || bubble_cnt !== 16'd3) begin
      errors++; $display("FAIL prereset got cnt %0d bub %0d exp 4 3", count, bubble_cnt);
    end
    do_reset(1'b1, 1'b1);
    checks++; if (count !== 3'd0 || bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL midreset got cnt %0d bub %0d exp 0 0", count, bubble_cnt);
    end
    checks++; if (ID_valid !== 1'b0 || IF_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_flags valid %b ready %b exp 0 1", ID_valid, IF_ready);
    end
  endtask

  initial begin
    reset_n = 1'b1; IF_valid = 1'b0; IF_instr = '0; IF_npc = '0;
    ID_ready = 1'b0; EX_MEM_PCSrc = 1'b0; m_bub = 0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_full_push_pop();
    test_stream();
    test_flush();
    test_bubble();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
